// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART byte transmitter.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
package uart_tx_pkg;

    localparam int DIV_W     = 24;
    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    localparam int FRAME_BITS = 10;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    localparam int unsigned BAUD_RATES [8] = '{
        32'd9600, 32'd19200, 32'd38400, 32'd57600,
        32'd115200, 32'd230400, 32'd460800, 32'd921600
    };

    // Clock cycles per bit for a baud code; integer division truncates.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel,
                                                  input int unsigned clk_freq);
        return DIV_W'(clk_freq / BAUD_RATES[sel]);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..div-1 while enabled and pulses bit_tick on the wrap cycle.
module uart_baud_gen
    import uart_tx_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign bit_tick = en && (cnt_reg == div - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (srst || clear || !en) begin
            cnt_reg <= '0;
        end else if (bit_tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// One-byte asynchronous UART transmitter (8N1, LSB first) with run-time baud select.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
module uart_byte_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Data,
    input  logic [2:0] baud_set,
    input  logic       send_en,
    output logic       uart_tx,
    output logic       tx_done
);

    // Reset_n is active-high despite its name.
    logic srst;
    assign srst = Reset_n;

    tx_state_t        state_reg, state_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       data_reg, data_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             tx_reg, tx_next;
    logic             done_reg, done_next;
    logic             frame_start;
    logic             bit_tick;

    uart_baud_gen u_baud_gen (
        .clk      (Clk),
        .srst     (srst),
        .en       (state_reg != ST_IDLE),
        .clear    (frame_start),
        .div      (div_reg),
        .bit_tick (bit_tick)
    );

    // bit_cnt_reg tracks the frame position: 0 = start, 1..8 = data, then parity/stop.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        div_next     = div_reg;
        tx_next      = tx_reg;
        done_next    = 1'b0;
        frame_start  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (send_en) begin
                    frame_start  = 1'b1;
                    state_next   = ST_START;
                    data_next    = Data;
                    div_next     = baud_div(baud_set, CLK_FREQ);
                    bit_cnt_next = 4'd0;
                    tx_next      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = 4'd1;
                    tx_next      = data_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
                        tx_next    = ^data_reg;
`else
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = data_reg[bit_cnt_reg[2:0]];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_next   = ST_STOP;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    tx_next      = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_next = 1'b1;
                if (bit_tick) begin
                    state_next   = ST_IDLE;
                    bit_cnt_next = 4'd0;
                    done_next    = (bit_cnt_reg == 4'(FRAME_BITS - 1));
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (srst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 4'd0;
            data_reg    <= 8'd0;
            div_reg     <= '0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            div_reg     <= div_next;
            tx_reg      <= tx_next;
            done_reg    <= done_next;
        end
    end

    assign uart_tx = tx_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Randomised self-checking bench for uart_byte_tx against a frame-level line model.
module tb_uart_byte_tx;

    localparam int unsigned CLK_FREQ = 50_000_000;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic [2:0] baud_set = 3'd0;
    logic       send_en = 1'b0;
    logic       uart_tx;
    logic       tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_frame = 0;

    int unsigned rates [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

    always #10 clk = ~clk;

    uart_byte_tx #(.CLK_FREQ(CLK_FREQ)) dut (
        .Clk      (clk),
        .Reset_n  (rst),
        .Data     (data),
        .baud_set (baud_set),
        .send_en  (send_en),
        .uart_tx  (uart_tx),
        .tx_done  (tx_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Line level expected at frame position idx: start, LSB-first data, [parity], stop.
    function automatic int exp_line(input logic [7:0] d, input int idx);
        if (idx == 0) return 0;
        if (idx <= 8) return int'(d[idx-1]);
        if (idx == NBITS - 1) return 1;
        return int'(^d);
    endfunction

    task automatic idle_check(input string tag, input int n);
        int ok = 0;
        repeat (n) begin
            @(negedge clk);
            if (uart_tx === 1'b1 && tx_done === 1'b0) ok++;
        end
        chk(tag, ok, n);
    endtask

    // Called at a negedge; requests a frame and checks every cycle of it.
    task automatic run_frame(input logic [7:0] d, input logic [2:0] sel,
                             input bit drop, input bit mutate);
        int div = int'(CLK_FREQ / rates[sel]);
        int gap = 0;
        int good;
        int dones = 0;
        logic ebit;
        data = d;
        baud_set = sel;
        send_en = 1'b1;
        do begin
            @(negedge clk);
            gap++;
        end while (uart_tx !== 1'b0 && gap < 8);
        chk("start_latency", gap, 1);
        for (int b = 0; b < NBITS; b++) begin
            good = 0;
            ebit = (exp_line(d, b) != 0);
            for (int c = 0; c < div; c++) begin
                if (b > 0 || c > 0) @(negedge clk);
                if (uart_tx === ebit) good++;
                if (tx_done !== 1'b0) dones++;
                if (mutate && b == 3 && c == 5) begin
                    data = 8'hFF;
                    baud_set = 3'd4;
                end
            end
            chk($sformatf("bit%0d_cycles", b), good, div);
        end
        chk("done_early", dones, 0);
        @(negedge clk);
        chk("done_pulse", int'(tx_done), 1);
        chk("line_after_stop", int'(uart_tx), 1);
        if (drop) send_en = 1'b0;
        n_frame++;
        $display("frame %0d: data=%02h baud_set=%0d div=%0d errors_so_far=%0d",
                 n_frame, d, sel, div, n_bad);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [2:0] s;

        rst = 1'b1;
        idle_check("reset_idle", 10);
        rst = 1'b0;
        idle_check("post_reset_idle", 1000);

        run_frame(8'hAB, 3'd4, 1'b1, 1'b0);
        idle_check("gap_idle", 1000);
        run_frame(8'h2E, 3'd4, 1'b1, 1'b0);
        idle_check("no_third_frame", 500);

        run_frame(8'h55, 3'd0, 1'b1, 1'b1);
        idle_check("slow_idle", 100);

        run_frame(8'h00, 3'd4, 1'b0, 1'b0);
        run_frame(8'h00, 3'd4, 1'b1, 1'b0);
        idle_check("b2b_idle", 100);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            s = 3'($urandom_range(6, 7));
            run_frame(d, s, 1'($urandom_range(0, 1)), 1'b0);
        end
        send_en = 1'b0;
        idle_check("random_idle", 100);

        // Abort during d[3] with d[3]=0 so the line visibly returns high.
        d = 8'($urandom) & 8'hF7;
        data = d;
        baud_set = 3'd4;
        send_en = 1'b1;
        @(negedge clk);
        chk("abort_start", int'(uart_tx), 0);
        repeat (4 * 434 + 200) @(negedge clk);
        chk("abort_in_d3", int'(uart_tx), 0);
        rst = 1'b1;
        send_en = 1'b0;
        @(negedge clk);
        chk("abort_line", int'(uart_tx), 1);
        chk("abort_done", int'(tx_done), 0);
        idle_check("abort_hold", 5);
        rst = 1'b0;
        $display("abort: data=%02h reset during d[3] errors_so_far=%0d", d, n_bad);
        idle_check("abort_quiet", 2 * 434 * NBITS);

        run_frame(8'($urandom), 3'd5, 1'b1, 1'b0);
        idle_check("final_idle", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Transmits one byte per request as an asynchronous UART frame: 8N1, LSB first, idle-high line.
- The baud rate is chosen at run time from a 3-bit code. Bit timing is derived from the system clock.
- Sits between a byte-producing controller and the physical TX pin.
- Completion is reported with a single-cycle done pulse.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; all baud divisors derive from it.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Reset_n  input  1  reset. Synchronous and active-high despite the name: Reset_n=1 at a rising edge resets the block.
- Data  input  8  byte to send; sampled only at frame start.
- baud_set  input  3  baud select; sampled only at frame start.
- send_en  input  1  level request; a frame starts when this is high while idle.
- uart_tx  output  1  serial line; idle 1.
- tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset: uart_tx=1, tx_done=0, state IDLE, all counters 0. Reset mid-frame aborts immediately: the line returns to 1 and no tx_done is issued.
- Baud map, as divisor DIV = CLK_FREQ/baud (integer division):
  - 0 = 9600
  - 1 = 19200
  - 2 = 38400
  - 3 = 57600
  - 4 = 115200
  - 5 = 230400
  - 6 = 460800
  - 7 = 921600
- Example at 50 MHz: DIV = 5208, 2604, 1302, 868, 434, 217, 108, 54.
- States: IDLE, START, DATA, STOP.
- IDLE → START:
  - Occurs at the first rising edge where send_en=1 in IDLE.
  - On that edge, Data and the DIV for baud_set are latched, and uart_tx goes 0 (registered output, visible right after that edge).
- Bit timing:
  - Each bit holds uart_tx for exactly DIV clock cycles, counted by a divisor counter that runs 0..DIV-1.
  - At DIV-1 the counter wraps and the block advances to the next bit.
- DATA state: sends latched bits d[0]..d[7] in order.
- STOP state: uart_tx=1 for DIV cycles.
- End of frame:
  - On the edge that ends the stop bit, tx_done=1 for exactly one cycle and the state returns to IDLE.
  - Frame length is 10*DIV cycles from the start-bit edge to the tx_done edge.
- Back-to-back frames: if send_en is still 1 in the IDLE cycle after tx_done, a new frame starts on that edge. The line is never held low between frames, because the stop bit has already completed.
- send_en is ignored while busy. Data and baud_set changes mid-frame have no effect.
- tx_done is never asserted outside the end of a frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: an even-parity bit (XOR of the latched data) is sent between d[7] and the stop bit. A PARITY state is added and the frame becomes 11*DIV cycles.
- When undefined: 8N1 only, with the behaviour exactly as above.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum
  - the baud-rate constants and a function mapping baud_set plus CLK_FREQ to DIV
  - the frame bit count
- A natural sub-module is uart_baud_gen. It takes an enable and a latched DIV, and produces a bit_tick pulse on counter wrap; it is reset when the frame starts.

Test Plan:
- Reset_n=1 for 10 cycles, then 0 → uart_tx=1 and tx_done=0 throughout reset and while idle for 1000 cycles.
- baud_set=4, Data=8'hAB, send_en held high until tx_done:
  - Line sequence is 0,1,1,0,1,0,1,0,1,1, each bit 434 cycles (8680 ns).
  - tx_done pulses exactly one cycle, 4340 cycles after the start edge.
- After the 8'hAB frame, send_en=0 for 20000 ns, then Data=8'h2E with send_en high:
  - Bits are 0,0,1,1,1,0,1,0,0,1, followed by a single tx_done.
  - send_en is dropped right after tx_done, so no third frame occurs.
- baud_set=0, Data=8'h55 → each bit lasts 5208 cycles. Change Data to 8'hFF and baud_set to 4 mid-frame → the transmitted bits and timing are unchanged.
- send_en held high continuously with Data=8'h00 → consecutive frames with the stop bit always 434 cycles high, and one tx_done per frame.
- Reset_n pulsed high during d[3] → uart_tx=1 on the next cycle, no tx_done, and a fresh frame starts cleanly after the release.
